// File: rtl/ct_spsram_256x7_ctrl_pkg.sv
// Shared types and constants for the 256x7 single-port array controller.
package ct_spsram_ctrl_pkg;

    localparam int unsigned CT_ADDR_W = 8;
    localparam int unsigned CT_DATA_W = 7;
    localparam int unsigned CT_DEPTH  = 1 << CT_ADDR_W;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic                 vld;
        logic                 wr;
        logic [CT_ADDR_W-1:0] addr;
        logic [CT_DATA_W-1:0] wdata;
        logic [CT_DATA_W-1:0] wmask;
    } access_t;

endpackage

// File: rtl/ct_spsram_256x7_ctrl_if.sv
// Requester-side bus of the array controller: two request channels plus shared read data.
interface ct_spsram_256x7_ctrl_if
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = CT_ADDR_W,
    parameter int unsigned DATA_W = CT_DATA_W
);

    logic              r0_vld;
    logic              r0_wr;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic [DATA_W-1:0] r0_wmask;
    logic              r0_gnt;
    logic              r0_rvld;

    logic              r1_vld;
    logic              r1_wr;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic [DATA_W-1:0] r1_wmask;
    logic              r1_gnt;
    logic              r1_rvld;

    logic [DATA_W-1:0] rdata;

    modport master (
        output r0_vld, r0_wr, r0_addr, r0_wdata, r0_wmask,
        output r1_vld, r1_wr, r1_addr, r1_wdata, r1_wmask,
        input  r0_gnt, r0_rvld, r1_gnt, r1_rvld, rdata
    );

    modport slave (
        input  r0_vld, r0_wr, r0_addr, r0_wdata, r0_wmask,
        input  r1_vld, r1_wr, r1_addr, r1_wdata, r1_wmask,
        output r0_gnt, r0_rvld, r1_gnt, r1_rvld, rdata
    );

endinterface

// File: rtl/ct_spsram_256x7_ctrl_arb.sv
// Two-way arbiter producing a one-hot grant; fixed r0-over-r1 priority, or
// round-robin when CT_SPSRAM_CTRL_RR_EN is defined.
module ct_spsram_ctrl_arb (
`ifdef CT_SPSRAM_CTRL_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] i_vld,
    output logic [1:0] o_gnt
);

`ifdef CT_SPSRAM_CTRL_RR_EN
    // r_rr_ptr names the requester preferred on the next contended cycle
    logic r_rr_ptr;

    always_comb begin
        o_gnt = i_vld;
        if (i_vld == 2'b11) begin
            o_gnt = r_rr_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (|o_gnt) begin
            r_rr_ptr <= o_gnt[0];
        end
    end
`else
    always_comb begin
        o_gnt = {i_vld[1] & ~i_vld[0], i_vld[0]};
    end
`endif

endmodule

// File: rtl/ct_spsram_256x7_ctrl.sv
// Init-sweep sequencer and two-requester port arbiter for a 256x7 single-port array.
// Define CT_SPSRAM_CTRL_RR_EN for round-robin arbitration (default: r0 over r1).
module ct_spsram_256x7_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = CT_ADDR_W,
    parameter int unsigned       DATA_W   = CT_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  flush_req,
    output logic                  init_done,
    ct_spsram_256x7_ctrl_if.slave req,
    output logic [ADDR_W-1:0]     sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_W-1:0]     sram_wen,
    output logic [DATA_W-1:0]     sram_d,
    input  logic [DATA_W-1:0]     sram_q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [1:0]        r_rvld;
    logic [1:0]        w_vld;
    logic [1:0]        w_gnt;
    logic              w_run;

    assign w_run = (r_state == RUN);
    assign w_vld = {req.r1_vld, req.r0_vld} & {2{w_run}};

    ct_spsram_ctrl_arb u_arb (
`ifdef CT_SPSRAM_CTRL_RR_EN
        .clk   (forever_cpuclk),
        .rst_n (cpurst_b),
`endif
        .i_vld (w_vld),
        .o_gnt (w_gnt)
    );

    assign req.r0_gnt  = w_gnt[0];
    assign req.r1_gnt  = w_gnt[1];
    assign req.r0_rvld = r_rvld[0];
    assign req.r1_rvld = r_rvld[1];
    assign req.rdata   = sram_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read tag is independent of the FSM so a read granted alongside a flush still returns.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rvld <= '0;
        end else begin
            r_rvld <= {w_gnt[1] & ~req.r1_wr, w_gnt[0] & ~req.r0_wr};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        init_done   = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;

        case (r_state)
            WAIT: begin
                w_state_nxt = INIT;
            end

            INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = r_cnt;
                sram_d    = INIT_VAL;
                if (flush_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end

            RUN: begin
                init_done = 1'b1;
                if (flush_req) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = '0;
                end
                if (w_gnt[0]) begin
                    sram_cen = 1'b0;
                    sram_a   = req.r0_addr;
                    if (req.r0_wr) begin
                        sram_gwen = 1'b0;
                        sram_wen  = ~req.r0_wmask;
                        sram_d    = req.r0_wdata;
                    end
                end else if (w_gnt[1]) begin
                    sram_cen = 1'b0;
                    sram_a   = req.r1_addr;
                    if (req.r1_wr) begin
                        sram_gwen = 1'b0;
                        sram_wen  = ~req.r1_wmask;
                        sram_d    = req.r1_wdata;
                    end
                end
            end

            default: begin
                w_state_nxt = WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_ct_spsram_256x7_ctrl.sv
// Scoreboard bench for ct_spsram_256x7_ctrl with a behavioural 256x7 array;
// honours CT_SPSRAM_CTRL_RR_EN in its arbitration model.
module tb_ct_spsram_256x7_ctrl;
    import ct_spsram_ctrl_pkg::*;

    localparam logic [6:0] INIT_V = 7'h00;

    logic       forever_cpuclk = 1'b0;
    logic       cpurst_b;
    logic       flush_req;
    logic       init_done;
    logic [7:0] sram_a;
    logic       sram_cen;
    logic       sram_gwen;
    logic [6:0] sram_wen;
    logic [6:0] sram_d;
    logic [6:0] sram_q;

    ct_spsram_256x7_ctrl_if #(.ADDR_W(8), .DATA_W(7)) bus ();

    ct_spsram_256x7_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (7),
        .INIT_VAL (INIT_V)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .flush_req      (flush_req),
        .init_done      (init_done),
        .req            (bus),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural array: Q registers on read and holds across writes.
    logic [6:0] mem [256];
    logic [6:0] q;
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (sram_gwen) begin
                q <= mem[sram_a];
            end else begin
                for (int b = 0; b < 7; b++) begin
                    if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
                end
            end
        end
    end
    assign sram_q = q;

    typedef struct {
        int         id;
        logic [6:0] data;
        int         cyc;
    } sb_t;

    sb_t        sb [$];
    logic [6:0] ref_mem [256];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         gid;
`ifdef CT_SPSRAM_CTRL_RR_EN
    logic       m_ptr = 1'b0;
`endif

    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic done, input logic cen, input logic gwen,
                                            input logic [6:0] wen, input logic [7:0] a,
                                            input logic [6:0] d);
        return {7'b0, done, cen, gwen, wen, a, d};
    endfunction

    function automatic logic [31:0] bus_word();
        return {7'b0, init_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d};
    endfunction

    function automatic access_t acc(input logic wr, input logic [7:0] addr,
                                    input logic [6:0] wdata, input logic [6:0] wmask);
        access_t a;
        a.vld   = 1'b1;
        a.wr    = wr;
        a.addr  = addr;
        a.wdata = wdata;
        a.wmask = wmask;
        return a;
    endfunction

    localparam access_t IDLE = '0;

    task automatic arb_model(input logic v0, input logic v1, output int g);
        g = -1;
`ifdef CT_SPSRAM_CTRL_RR_EN
        if (v0 && v1)  g = m_ptr ? 1 : 0;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        if (g >= 0) m_ptr = (g == 0);
`else
        if (v0)        g = 0;
        else if (v1)   g = 1;
`endif
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_cycle(input access_t a0, input access_t a1, input logic fl, output int g);
        access_t     w;
        logic [31:0] e;
        bus.r0_vld = a0.vld; bus.r0_wr = a0.wr; bus.r0_addr = a0.addr;
        bus.r0_wdata = a0.wdata; bus.r0_wmask = a0.wmask;
        bus.r1_vld = a1.vld; bus.r1_wr = a1.wr; bus.r1_addr = a1.addr;
        bus.r1_wdata = a1.wdata; bus.r1_wmask = a1.wmask;
        flush_req = fl;
        arb_model(a0.vld, a1.vld, g);
        w = (g == 1) ? a1 : a0;
        @(negedge forever_cpuclk);
        chk("gnt", {30'b0, bus.r1_gnt, bus.r0_gnt}, (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
        if (g < 0)     e = mk_word(1'b1, 1'b1, 1'b1, '1, 8'h00, 7'h00);
        else if (w.wr) e = mk_word(1'b1, 1'b0, 1'b0, ~w.wmask, w.addr, w.wdata);
        else           e = mk_word(1'b1, 1'b0, 1'b1, '1, w.addr, 7'h00);
        chk("sram_ctl", bus_word(), e);
        if (g >= 0) begin
            if (w.wr) ref_mem[w.addr] = (ref_mem[w.addr] & ~w.wmask) | (w.wdata & w.wmask);
            else      sb.push_back('{g, ref_mem[w.addr], cyc + 1});
        end
        @(posedge forever_cpuclk);
        #1;
        bus.r0_vld = 1'b0;
        bus.r1_vld = 1'b0;
        flush_req  = 1'b0;
    endtask

    // k = 0 is the WAIT cycle, 1..256 write addresses 0..255, 257 is the first RUN cycle.
    task automatic sweep_check(input int k0, input string tag);
        logic [31:0] e;
        for (int k = k0; k <= 257; k++) begin
            @(negedge forever_cpuclk);
            if (k == 0)        e = mk_word(1'b0, 1'b1, 1'b1, '1, 8'h00, 7'h00);
            else if (k <= 256) e = mk_word(1'b0, 1'b0, 1'b0, '0, 8'(k - 1), INIT_V);
            else               e = mk_word(1'b1, 1'b1, 1'b1, '1, 8'h00, 7'h00);
            chk(tag, bus_word(), e);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = INIT_V;
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Read-return monitor
    always @(negedge forever_cpuclk) begin
        sb_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("rvld_missing", 32'd0, 32'd1);
        end
        if (bus.r0_rvld || bus.r1_rvld) begin
            if (sb.size() == 0) begin
                chk("rvld_spurious", {30'b0, bus.r1_rvld, bus.r0_rvld}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvld_cyc", cyc, e.cyc);
                chk("rvld_who", {30'b0, bus.r1_rvld, bus.r0_rvld}, (e.id == 0) ? 32'd1 : 32'd2);
                chk("rdata", {25'b0, bus.rdata}, {25'b0, e.data});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int i0;
        int i1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 7'($urandom);
            ref_mem[i] = 7'h00;
        end
        cpurst_b  = 1'b0;
        flush_req = 1'b0;
        bus.r0_vld = 1'b1; bus.r0_wr = 1'b0; bus.r0_addr = 8'h00;
        bus.r0_wdata = '0; bus.r0_wmask = '0;
        bus.r1_vld = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = 8'h00;
        bus.r1_wdata = '0; bus.r1_wmask = '0;

        repeat (3) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("rst_word", bus_word(), mk_word(1'b0, 1'b1, 1'b1, '1, 8'h00, 7'h00));
        chk("rst_hs", {28'b0, bus.r1_gnt, bus.r0_gnt, bus.r1_rvld, bus.r0_rvld}, 32'd0);
        bus.r0_vld = 1'b0;
        bus.r1_vld = 1'b0;
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        sweep_check(0, "sweep_rst");

        do_cycle(acc(1'b0, 8'h5A, 7'h00, 7'h00), IDLE, 1'b0, gid);

        // Masked write, zero-mask write, then read-before-write on the same address
        do_cycle(acc(1'b1, 8'h10, 7'h7F, 7'h0F), IDLE, 1'b0, gid);
        do_cycle(acc(1'b0, 8'h10, 7'h00, 7'h00), IDLE, 1'b0, gid);
        do_cycle(acc(1'b1, 8'h10, 7'h55, 7'h00), IDLE, 1'b0, gid);
        do_cycle(acc(1'b0, 8'h10, 7'h00, 7'h00), IDLE, 1'b0, gid);
        do_cycle(acc(1'b1, 8'h10, 7'h2A, 7'h7F), IDLE, 1'b0, gid);
        do_cycle(acc(1'b0, 8'h10, 7'h00, 7'h00), IDLE, 1'b0, gid);

        for (int i = 0; i < 4; i++)
            do_cycle(acc(1'b1, 8'(32'h20 + i), 7'(32'h11 * (i + 1)), 7'h7F), IDLE, 1'b0, gid);
        for (int i = 0; i < 4; i++)
            do_cycle(IDLE, acc(1'b1, 8'(32'h30 + i), 7'(32'h60 + i), 7'h7F), 1'b0, gid);

        // Both requesters contend for four cycles
        i0 = 0;
        i1 = 0;
        for (int n = 0; n < 4; n++) begin
            do_cycle(acc(1'b0, 8'(32'h20 + i0), 7'h00, 7'h00),
                     acc(1'b0, 8'(32'h30 + i1), 7'h00, 7'h00), 1'b0, gid);
            if (gid == 0) i0++;
            else if (gid == 1) i1++;
        end

        // Flush alongside a granted r1 read, then read the whole array back
        do_cycle(IDLE, acc(1'b0, 8'h31, 7'h00, 7'h00), 1'b1, gid);
        sweep_check(1, "sweep_flush");
        for (int i = 0; i < 256; i++)
            do_cycle(acc(1'b0, 8'(i), 7'h00, 7'h00), IDLE, 1'b0, gid);

        // Reset asserted in the middle of a sweep
        do_cycle(IDLE, IDLE, 1'b1, gid);
        repeat (100) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("cnt100", {24'b0, sram_a}, 32'd100);
        #1;
        cpurst_b = 1'b0;
`ifdef CT_SPSRAM_CTRL_RR_EN
        m_ptr = 1'b0;
`endif
        #1;
        chk("async_rst", bus_word(), mk_word(1'b0, 1'b1, 1'b1, '1, 8'h00, 7'h00));
        @(posedge forever_cpuclk);
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        sweep_check(0, "sweep_rerst");

        do_cycle(acc(1'b1, 8'hFF, 7'h5C, 7'h3C), IDLE, 1'b0, gid);
        do_cycle(IDLE, acc(1'b0, 8'hFF, 7'h00, 7'h00), 1'b0, gid);
        do_cycle(acc(1'b0, 8'h10, 7'h00, 7'h00), IDLE, 1'b0, gid);

        repeat (2) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ct_spsram_256x7_ctrl.md
Name: ct_spsram_256x7_ctrl

Overview:
Sequencer and arbiter in front of one ct_f_spsram_256x7 single-port array (256 entries x 7 bits). After reset, and on a flush request, it sweeps all 256 entries to a fixed init value. After the sweep it shares the single port between two requesters, each able to read or do a bit-masked write. It converts requester signals to the array's active-low CEN/GWEN/WEN controls and returns read data with a per-requester valid.

Parameters:
ADDR_W, 8, array address width; depth = 2**ADDR_W
DATA_W, 7, array data width
INIT_VAL, 7'b0, value written to every entry during the sweep

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  reset, asynchronous, active-low
flush_req  in  1  one-cycle pulse: re-run the init sweep
init_done  out  1  high once the sweep is complete and the array is serviceable
r0_vld  in  1  requester 0 request
r0_wr  in  1  1 = write, 0 = read
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_wmask  in  DATA_W  active-high bit write mask
r0_gnt  out  1  requester 0 request accepted this cycle
r0_rvld  out  1  requester 0 read data valid
r1_vld / r1_wr / r1_addr / r1_wdata / r1_wmask  in  as r0  requester 1 request
r1_gnt  out  1  requester 1 request accepted this cycle
r1_rvld  out  1  requester 1 read data valid
rdata  out  DATA_W  read data, shared by both requesters; qualified by rN_rvld
sram_a  out  ADDR_W  to array A
sram_cen  out  1  to array CEN (active-low)
sram_gwen  out  1  to array GWEN (active-low)
sram_wen  out  DATA_W  to array WEN (active-low, per bit)
sram_d  out  DATA_W  to array D
sram_q  in  DATA_W  from array Q

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset cpurst_b is asynchronous and active-low.
- Reset values: FSM = WAIT, cnt = 0, init_done = 0, rN_gnt = 0, rN_rvld = 0, rr_ptr = 0.
- SRAM outputs are combinational; in WAIT with no grant: sram_cen = 1, sram_gwen = 1, sram_wen = all-1, sram_a = 0, sram_d = 0.
- FSM states: WAIT, INIT, RUN.
  - WAIT: always moves to INIT the next cycle.
  - INIT: each cycle drives sram_cen = 0, sram_gwen = 0, sram_wen = 0, sram_a = cnt, sram_d = INIT_VAL, then cnt++. When cnt == 255, cnt wraps to 0 and the FSM moves to RUN.
  - RUN: init_done = 1.
- Sweep timing: from reset release, the sweep takes exactly 1 + 256 cycles. init_done rises in the cycle after the write to address 255.
- flush_req:
  - In RUN: the next state is INIT with cnt = 0, and init_done drops the next cycle.
  - In INIT: restarts cnt at 0.
  - In WAIT: ignored.
- Grants: valid only in RUN, decided combinationally in the same cycle; at most one grant per cycle.
  - Default arbitration: fixed priority, r0 over r1.
  - When flush_req is seen in RUN, that cycle's grant is still honoured.
- Granted access:
  - sram_cen = 0 and sram_a = addr.
  - Write: sram_gwen = 0, sram_wen = ~wmask, sram_d = wdata. A write with wmask = 0 still consumes the slot and changes no bits.
  - Read: sram_gwen = 1, sram_wen = all-1.
- Read return: a read granted in cycle t gives rN_rvld = 1 in t+1 with rdata = sram_q. The registered read tag survives a flush or FSM transition; rvld is still returned.
- Back-to-back: one access per cycle is sustained. A read in t and a write in t+1 to the same address returns the old data in t+1.
- Requester contract: a requester holds its vld and payload until gnt; the controller does not buffer requests.

Optional Feature:
- Macro: CT_SPSRAM_CTRL_RR_EN.
- When defined: round-robin arbitration. A 1-bit rr_ptr names the preferred requester; on any grant it updates to point to the non-granted requester. A lone requester is always granted.
- When undefined: fixed priority, r0 over r1, and rr_ptr is absent.

Decomposition:
- Shared package ct_spsram_ctrl_pkg holds:
  - the FSM state enum (WAIT/INIT/RUN);
  - ADDR_W/DATA_W defaults and the depth constant;
  - an access struct {vld, wr, addr, wdata, wmask}.
- One sub-module, ct_spsram_ctrl_arb: the 2-way arbiter, fixed or RR under the macro. Input is vld[1:0]; output is a one-hot gnt.

Test Plan:
- Reset release -> exactly 257 cycles with init_done low and writes to addresses 0..255 with D = 0; then a read of address 0x5A returns rdata = 0 with r0_rvld one cycle after grant.
- r0 writes 0x7F to address 0x10 with wmask 0x0F; then r0 reads 0x10 -> rdata = 0x0F.
- r0 and r1 both valid for 4 cycles:
  - fixed priority: r0 granted 4 times.
  - with CT_SPSRAM_CTRL_RR_EN: grants alternate r0, r1, r0, r1.
- flush_req in the same cycle as a granted r1 read -> r1_rvld still pulses next cycle; init_done drops, and after 256 cycles all entries read back as 0.
- cpurst_b asserted at cnt = 100 -> the sweep restarts from address 0 after release; init_done stays low for 257 cycles.
